// File: rtl/calc_display_pkg.sv
// Shared nibble codes and active-low 7-segment glyphs for the calculator display path.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights that segment.
package calc_display_pkg;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_MINUS = 4'hA;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder for one active-low common-anode digit.
// blank_force overrides the nibble (used for leading-zero suppression).
module seg7_decode
  import calc_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank_force,
  output logic [6:0] seg_n
);

  // Codes 4'hB-4'hF fall through to blank.
  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank_force) begin
      case (nibble)
        4'd0:      seg_n = SEG_DIGIT[0];
        4'd1:      seg_n = SEG_DIGIT[1];
        4'd2:      seg_n = SEG_DIGIT[2];
        4'd3:      seg_n = SEG_DIGIT[3];
        4'd4:      seg_n = SEG_DIGIT[4];
        4'd5:      seg_n = SEG_DIGIT[5];
        4'd6:      seg_n = SEG_DIGIT[6];
        4'd7:      seg_n = SEG_DIGIT[7];
        4'd8:      seg_n = SEG_DIGIT[8];
        4'd9:      seg_n = SEG_DIGIT[9];
        NIB_MINUS: seg_n = SEG_MINUS;
        default:   seg_n = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment bank, snapshotting bcd_in once per frame.
// Optional leading-zero blanking is enabled by defining BCD_DISP_LEADING_ZERO_BLANK_EN.
module bcd_display_scan
  import calc_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 11,
  parameter int REFRESH_DIV  = 50000,
  parameter int DIV_W        = 16,
  parameter int GHOST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] frame_reg;
  logic                    slot_end;
  logic                    snap_now;
  logic                    ghost;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              sel_nib;
  logic                    sel_blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              dec_seg;

  assign slot_end = (prescaler == DIV_W'(REFRESH_DIV - 1));
  assign snap_now = (prescaler == '0) && (digit_idx == '0);
  assign ghost    = (prescaler < DIV_W'(GHOST_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler   <= '0;
      digit_idx   <= '0;
      frame_reg   <= '1;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= slot_end ? '0 : prescaler + DIV_W'(1);
      frame_start <= snap_now;
      if (slot_end) begin
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end
      if (snap_now) begin
        frame_reg <= bcd_in;
      end
    end
  end

`ifdef BCD_DISP_LEADING_ZERO_BLANK_EN
  // Walk from the most-significant digit down; blanking survives only through 0/blank nibbles.
  logic       above_ok;
  logic [3:0] lz_nib;

  always_comb begin
    lz_blank = '0;
    above_ok = 1'b1;
    lz_nib   = 4'h0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_nib = frame_reg[4*k +: 4];
      if (k > 0) begin
        lz_blank[k] = above_ok && (lz_nib == 4'h0);
      end
      above_ok = above_ok && ((lz_nib == 4'h0) || (lz_nib == NIB_BLANK));
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    sel_nib   = NIB_BLANK;
    sel_blank = 1'b0;
    an_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        sel_nib    = frame_reg[4*k +: 4];
        sel_blank  = lz_blank[k];
        an_next[k] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .nibble      (sel_nib),
    .blank_force (sel_blank),
    .seg_n       (dec_seg)
  );

  // Anodes stay off for the first GHOST_CYCLES of each slot to hide segment ghosting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_n <= SEG_BLANK;
      an_n  <= '1;
    end else if (ghost) begin
      seg_n <= SEG_BLANK;
      an_n  <= '1;
    end else begin
      seg_n <= dec_seg;
      an_n  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan against a cycle-count-based reference model.
// Leading-zero expectations follow BCD_DISP_LEADING_ZERO_BLANK_EN as defined for the build.
module tb_bcd_display_scan;

  localparam int ND    = 11;
  localparam int RD    = 4;
  localparam int GHOST = 1;
  localparam int FRAME = ND * RD;

  logic            clk;
  logic            reset;
  logic [4*ND-1:0] bcd_in;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;
  logic            frame_start;

  int n_compared;
  int n_mismatched;

  // Model state: cycles since the last reset release and the digits latched at frame start.
  int         t;
  logic [3:0] snap [ND];
  logic [6:0] exp_seg;
  logic [ND-1:0] exp_an;
  logic       exp_fs;

  bcd_display_scan #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .DIV_W        (16),
    .GHOST_CYCLES (GHOST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_in),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] nib, input bit blank);
    logic [6:0] table_g [0:9];
    table_g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (blank) return 7'h7F;
    if (nib <= 4'd9) return table_g[nib];
    if (nib == 4'hA) return 7'h3F;
    return 7'h7F;
  endfunction

  function automatic bit lzBlank(input int k);
`ifdef BCD_DISP_LEADING_ZERO_BLANK_EN
    if (k == 0 || snap[k] != 4'h0) return 1'b0;
    for (int j = k + 1; j < ND; j++) begin
      if (snap[j] != 4'h0 && snap[j] != 4'hF) return 1'b0;
    end
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  task automatic modelStep(input logic r, input logic [4*ND-1:0] word);
    int slot;
    int phase;
    if (!r) begin
      t = 0;
      for (int k = 0; k < ND; k++) snap[k] = 4'hF;
      exp_seg = 7'h7F;
      exp_an  = '1;
      exp_fs  = 1'b0;
    end else begin
      slot  = (t / RD) % ND;
      phase = t % RD;
      exp_fs = ((t % FRAME) == 0);
      if (phase < GHOST) begin
        exp_seg = 7'h7F;
        exp_an  = '1;
      end else begin
        exp_an  = ~(ND'(1) << slot);
        exp_seg = glyph(snap[slot], lzBlank(slot));
      end
      if (exp_fs) begin
        for (int k = 0; k < ND; k++) snap[k] = word[4*k +: 4];
      end
      t++;
    end
  endtask

  task automatic checkOutput();
    n_compared++;
    assert (seg_n === exp_seg) else begin
      n_mismatched++;
      $error("[TB] FAIL seg_n t=%0d observed=%h expected=%h", t, seg_n, exp_seg);
    end
    n_compared++;
    assert (an_n === exp_an) else begin
      n_mismatched++;
      $error("[TB] FAIL an_n t=%0d observed=%h expected=%h", t, an_n, exp_an);
    end
    n_compared++;
    assert (frame_start === exp_fs) else begin
      n_mismatched++;
      $error("[TB] FAIL frame_start t=%0d observed=%b expected=%b", t, frame_start, exp_fs);
    end
  endtask

  task automatic checkConst(input string tag, input logic [6:0] want_seg, input logic [ND-1:0] want_an);
    n_compared++;
    assert (seg_n === want_seg && an_n === want_an) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h/%h expected=%h/%h", tag, seg_n, an_n, want_seg, want_an);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare just after the edge.
  task automatic applyStimulus(input logic r, input logic [4*ND-1:0] word);
    reset  = r;
    bcd_in = word;
    @(posedge clk);
    modelStep(r, word);
    #1;
    checkOutput();
  endtask

  function automatic logic [4*ND-1:0] randWord();
    logic [4*ND-1:0] w;
    for (int k = 0; k < ND; k++) begin
      case ($urandom_range(0, 3))
        0:       w[4*k +: 4] = 4'h0;
        1:       w[4*k +: 4] = 4'hF;
        default: w[4*k +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return w;
  endfunction

  initial begin
    logic [4*ND-1:0] word;
    logic [63:0]     r64;
    n_compared   = 0;
    n_mismatched = 0;
    t            = 0;
    reset        = 1'b0;
    bcd_in       = '0;
    #1;

    $display("[TB] step 1: reset held low");
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      applyStimulus(1'b0, r64[4*ND-1:0]);
      checkConst("reset_blank", 7'h7F, 11'h7FF);
    end

    $display("[TB] step 2: release with 0123");
    word = 44'hFFFFFFF0123;
    applyStimulus(1'b1, word);
    checkConst("first_ghost", 7'h7F, 11'h7FF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, word);
      checkConst("digit0_three", 7'h30, 11'h7FE);
    end
    for (int i = 4; i < FRAME; i++) applyStimulus(1'b1, word);

    $display("[TB] step 3: change word mid-frame");
    for (int i = 0; i < 5 * RD; i++) applyStimulus(1'b1, word);
    word = 44'hFFFFFFFF999;
    for (int i = 5 * RD; i < FRAME; i++) applyStimulus(1'b1, word);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, word);

    $display("[TB] step 4: minus and unused codes");
    word = 44'hFFFFCFFFA42;
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, word);

    $display("[TB] step 5: leading zeros");
    word = 44'h00000000070;
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b1, word);

    $display("[TB] step 6: reset pulse during digit 7");
    while (((t / RD) % ND) != 7) applyStimulus(1'b1, word);
    applyStimulus(1'b1, word);
    applyStimulus(1'b0, word);
    checkConst("midscan_reset", 7'h7F, 11'h7FF);
    word = 44'hFFFFFFF5678;
    for (int i = 0; i < FRAME + 6; i++) applyStimulus(1'b1, word);

    $display("[TB] step 7: random words and resets");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) word = randWord();
      applyStimulus(($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1, word);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
